// File: rtl/i3c_sdr_bit_engine_pkg.sv
// Shared controller state codes, SDR framing constants and engine phase encoding
// for the I3C SDR bit engine.
package i3c_sdr_bit_engine_pkg;

  localparam int STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_START   = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_ADDRESS = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_DATA    = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_STOP    = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_ERROR   = 3'd5;

  localparam int SDR_BITS = 9;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_START,
    PH_ADDR,
    PH_DATA,
    PH_STOP
  } phase_e;

  // ERROR shares the STOP waveform so the bus is always released cleanly.
  function automatic phase_e phase_for_state(input logic [STATE_WIDTH-1:0] st);
    case (st)
      ST_START:          return PH_START;
      ST_ADDRESS:        return PH_ADDR;
      ST_DATA:           return PH_DATA;
      ST_STOP, ST_ERROR: return PH_STOP;
      default:           return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i3c_sdr_bit_engine_scl_divider.sv
// SCL half-period divider: counts CLK_DIV clocks per half and tracks which half
// (low/high) of the bit slot is active; restarts from the low half on clear.
module i3c_sdr_bit_engine_scl_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic scl_phase
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign half_tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt       <= '0;
      scl_phase <= 1'b0;
    end else if (half_tick) begin
      cnt       <= '0;
      scl_phase <= ~scl_phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i3c_sdr_bit_engine.sv
// I3C SDR bit engine: turns controller state codes into START / address / data /
// STOP waveforms on SCL and SDA and reports ACK and data-phase status.
module i3c_sdr_bit_engine
  import i3c_sdr_bit_engine_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [STATE_WIDTH-1:0] state_i,
  input  logic [6:0]             addr_i,
  input  logic                   rnw_i,
  input  logic [7:0]             wdata_i,
  input  logic                   sda_i,
  output logic                   scl_o,
  output logic                   sda_o,
  output logic                   sda_oe_o,
  output logic [7:0]             rdata_o,
  output logic                   addr_done_o,
  output logic                   addr_acked_o,
  output logic                   data_done_o,
  output logic                   data_acked_o,
  output logic                   busy_o
);

  logic [STATE_WIDTH-1:0] state_q;
  phase_e                 phase_q, phase_d, launch_phase;
  logic                   launch, half_tick, scl_phase, slot_end, last_slot, bus_clash;
  logic [3:0]             bit_cnt;
  logic [SDR_BITS-1:0]    tx_sh;
  logic [7:0]             rx_sh;
  logic                   rnw_q, contention_q;

  assign launch       = (state_i != state_q);
  assign launch_phase = phase_for_state(state_i);
  assign slot_end     = half_tick & scl_phase;
  assign last_slot    = (bit_cnt == 4'(SDR_BITS - 1));
  assign bus_clash    = tx_sh[SDR_BITS-1] & ~sda_i;

  i3c_sdr_bit_engine_scl_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (launch),
    .half_tick (half_tick),
    .scl_phase (scl_phase)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= PH_IDLE;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (launch) begin
      phase_d = launch_phase;
    end else begin
      case (phase_q)
        PH_START:         if (slot_end) phase_d = PH_IDLE;
        PH_ADDR, PH_DATA: if (slot_end && last_slot) phase_d = PH_IDLE;
        PH_STOP:          if (half_tick && bit_cnt == 4'd1) phase_d = PH_IDLE;
        default:          phase_d = PH_IDLE;
      endcase
    end
  end

  always_comb begin
    scl_o    = 1'b1;
    sda_o    = 1'b1;
    sda_oe_o = 1'b0;
    busy_o   = 1'b0;
    case (phase_q)
      PH_START: begin
        busy_o   = 1'b1;
        sda_oe_o = 1'b1;
        sda_o    = ~scl_phase;
      end
      PH_ADDR: begin
        busy_o   = 1'b1;
        scl_o    = scl_phase;
        sda_oe_o = ~last_slot;
        sda_o    = tx_sh[SDR_BITS-1];
      end
      PH_DATA: begin
        busy_o   = 1'b1;
        scl_o    = scl_phase;
        sda_oe_o = ~rnw_q;
        sda_o    = tx_sh[SDR_BITS-1];
      end
      PH_STOP: begin
        busy_o   = 1'b1;
        sda_oe_o = 1'b1;
        scl_o    = (bit_cnt == 4'd0) ? scl_phase : 1'b1;
        sda_o    = (bit_cnt != 4'd0);
      end
      default: ;
    endcase
  end

  // A launch always wins over a completing slot, so an abandoned phase never pulses done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt      <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      rnw_q        <= 1'b0;
      contention_q <= 1'b0;
      rdata_o      <= '0;
      addr_done_o  <= 1'b0;
      addr_acked_o <= 1'b0;
      data_done_o  <= 1'b0;
      data_acked_o <= 1'b0;
    end else begin
      state_q     <= state_i;
      addr_done_o <= 1'b0;
      data_done_o <= 1'b0;
      if (launch) begin
        bit_cnt      <= '0;
        contention_q <= 1'b0;
        rx_sh        <= '0;
        if (launch_phase == PH_ADDR) begin
          tx_sh        <= {addr_i, rnw_i, 1'b1};
          rnw_q        <= rnw_i;
          addr_acked_o <= 1'b0;
        end
        if (launch_phase == PH_DATA) begin
          tx_sh        <= {wdata_i, ~^wdata_i};
          rnw_q        <= rnw_i;
          data_acked_o <= 1'b0;
        end
      end else if (phase_q != PH_IDLE && slot_end) begin
        bit_cnt <= bit_cnt + 4'd1;
        tx_sh   <= {tx_sh[SDR_BITS-2:0], 1'b0};
        if (phase_q == PH_ADDR && last_slot) begin
          addr_done_o  <= 1'b1;
          addr_acked_o <= ~sda_i;
        end
        if (phase_q == PH_DATA) begin
          if (rnw_q && !last_slot) rx_sh <= {rx_sh[6:0], sda_i};
          if (!rnw_q && bus_clash) contention_q <= 1'b1;
          if (last_slot) begin
            data_done_o <= 1'b1;
            if (rnw_q) begin
              rdata_o      <= rx_sh;
              data_acked_o <= ^{rx_sh, sda_i};
            end else begin
              data_acked_o <= ~(contention_q | bus_clash);
            end
          end
        end
      end
    end
  end

endmodule
